// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer: queues host commands and issues them one at a time to the BIDS22 controller, returning one response per command
module bids22_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [31:0]              cmd_data,
  output logic [3:0]               C_op,
  output logic [31:0]              C_data,
  output logic                     C_start,
  input  logic                     bids_ready,
  input  logic [2:0]               bids_err,
  output logic                     rsp_valid,
  output logic [3:0]               rsp_op,
  output logic [2:0]               rsp_err,
  output logic                     rsp_illegal,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DROP} state_t;
  state_t        state;
  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] wait_cnt;
  logic          drop_illegal;
  logic [3:0]    head_op;
  logic [31:0]   head_data;
  logic          push, pop;
  assign cmd_ready = fifo_count != FULL;
  assign push = cmd_valid && cmd_ready;
  assign pop = state == ISSUE || state == DROP;
  assign {head_op, head_data} = mem[rd_ptr];
  // command storage, written on every accepted push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_op, cmd_data};
  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  // issue FSM: controller strobe is registered on entry to ISSUE, responses one cycle after CAPTURE or DROP
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      drop_illegal <= 1'b0;
      C_start <= 1'b0;
      C_op <= '0;
      C_data <= '0;
      rsp_valid <= 1'b0;
      rsp_op <= '0;
      rsp_err <= '0;
      rsp_illegal <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      C_start <= 1'b0;
      C_op <= '0;
      C_data <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE:
          if (fifo_count == '0) wait_cnt <= '0;
          else if (head_op > 4'd9) begin
            drop_illegal <= 1'b1;
            wait_cnt <= '0;
            state <= DROP;
          end else if (bids_ready) begin
            wait_cnt <= '0;
            C_start <= 1'b1;
            C_op <= head_op;
            C_data <= head_data;
            state <= ISSUE;
          end else if (wait_cnt == TLAST) begin
            drop_illegal <= 1'b0;
            wait_cnt <= '0;
            state <= DROP;
          end else wait_cnt <= wait_cnt + TW'(1);
        ISSUE: begin
          rsp_op <= head_op;
          state <= CAPTURE;
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_err <= bids_err;
          rsp_illegal <= 1'b0;
          rsp_timeout <= 1'b0;
          state <= IDLE;
        end
        DROP: begin
          rsp_valid <= 1'b1;
          rsp_op <= head_op;
          rsp_err <= '0;
          rsp_illegal <= drop_illegal;
          rsp_timeout <= !drop_illegal;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
// tb_bids22_cmd_sequencer: directed scenario bench for the command sequencer
module tb_bids22_cmd_sequencer;
  logic clk = 0, reset = 1, cmd_valid = 0, bids_ready = 0;
  logic [3:0] cmd_op = 0;
  logic [31:0] cmd_data = 0;
  logic [2:0] bids_err = 0;
  logic cmd_ready, C_start, rsp_valid, rsp_illegal, rsp_timeout;
  logic [3:0] C_op, rsp_op;
  logic [31:0] C_data;
  logic [2:0] rsp_err;
  logic [2:0] fifo_count;
  int pass = 0, total = 0, cyc = 0;
  logic [35:0] push_q[$], st_q[$];
  logic [8:0] rsp_q[$];
  logic [2:0] err_q[$];
  int acc_cyc[$], st_cyc[$], rsp_cyc[$];

  bids22_cmd_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .C_op(C_op), .C_data(C_data), .C_start(C_start), .bids_ready(bids_ready),
    .bids_err(bids_err), .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic step();
    bit acc;
    acc = cmd_valid && cmd_ready;
    @(posedge clk); #1; cyc++;
    if (acc) begin void'(push_q.pop_front()); acc_cyc.push_back(cyc); end
    if (C_start) begin
      st_q.push_back({C_op, C_data}); st_cyc.push_back(cyc);
      bids_err = err_q.size() != 0 ? err_q.pop_front() : 3'd0;
    end
    if (rsp_valid) begin rsp_q.push_back({rsp_op, rsp_err, rsp_illegal, rsp_timeout}); rsp_cyc.push_back(cyc); end
    cmd_valid = push_q.size() != 0;
    cmd_op = cmd_valid ? push_q[0][35:32] : 4'd0;
    cmd_data = cmd_valid ? push_q[0][31:0] : 32'd0;
  endtask

  task automatic clr();
    push_q.delete(); st_q.delete(); rsp_q.delete(); err_q.delete();
    acc_cyc.delete(); st_cyc.delete(); rsp_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    reset = 0;
    step();
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else pass++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); else pass++;
    total++; if ({C_start, C_op, C_data} !== 37'd0) $display("FAIL reset_ctrl: got %0h expected 0", {C_start, C_op, C_data}); else pass++;
    total++; if ({rsp_valid, rsp_op, rsp_err, rsp_illegal, rsp_timeout} !== 10'd0)
      $display("FAIL reset_rsp: got %0h expected 0", {rsp_valid, rsp_op, rsp_err, rsp_illegal, rsp_timeout}); else pass++;
  endtask

  task automatic test_single();
    clr(); bids_ready = 1; err_q.push_back(3'd0);
    push_q.push_back({4'd1, 32'h0});
    repeat (8) step();
    total++; if (st_q.size() !== 1 || rsp_q.size() !== 1) $display("FAIL single_counts: got %0d/%0d expected 1/1", st_q.size(), rsp_q.size());
    else begin
      pass++;
      total++; if (st_q[0] !== {4'd1, 32'h0}) $display("FAIL single_issue: got %0h expected %0h", st_q[0], {4'd1, 32'h0}); else pass++;
      total++; if (st_cyc[0] !== acc_cyc[0] + 1) $display("FAIL single_issue_lat: got %0d expected %0d", st_cyc[0], acc_cyc[0] + 1); else pass++;
      total++; if (rsp_cyc[0] !== st_cyc[0] + 2) $display("FAIL single_rsp_lat: got %0d expected %0d", rsp_cyc[0], st_cyc[0] + 2); else pass++;
      total++; if (rsp_q[0] !== {4'd1, 3'd0, 2'b00}) $display("FAIL single_rsp: got %0h expected %0h", rsp_q[0], {4'd1, 3'd0, 2'b00}); else pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] cmds [3];
    logic [2:0] errs [3];
    cmds = '{{4'd3, 32'hFFFF_FFFF}, {4'd4, 32'h1234_5678}, {4'd5, 32'h0}};
    errs = '{3'd0, 3'd2, 3'd0};
    clr(); bids_ready = 1;
    for (int i = 0; i < 3; i++) begin push_q.push_back(cmds[i]); err_q.push_back(errs[i]); end
    repeat (16) step();
    total++; if (st_q.size() !== 3 || rsp_q.size() !== 3) $display("FAIL b2b_counts: got %0d/%0d expected 3/3", st_q.size(), rsp_q.size());
    else begin
      pass++;
      for (int i = 0; i < 3; i++) begin
        total++; if (st_q[i] !== cmds[i]) $display("FAIL b2b_issue%0d: got %0h expected %0h", i, st_q[i], cmds[i]); else pass++;
        total++; if (rsp_q[i] !== {cmds[i][35:32], errs[i], 2'b00}) $display("FAIL b2b_rsp%0d: got %0h expected %0h", i, rsp_q[i], {cmds[i][35:32], errs[i], 2'b00}); else pass++;
      end
      total++; if (st_cyc[1] - st_cyc[0] !== 3 || st_cyc[2] - st_cyc[1] !== 3)
        $display("FAIL b2b_spacing: got %0d,%0d expected 3,3", st_cyc[1] - st_cyc[0], st_cyc[2] - st_cyc[1]); else pass++;
    end
  endtask

  task automatic test_full_fifo();
    clr(); bids_ready = 0;
    for (int i = 0; i < 5; i++) push_q.push_back({4'(i + 1), 32'(i + 100)});
    for (int i = 0; i < 10 && acc_cyc.size() < 4; i++) step();
    total++; if (fifo_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", fifo_count); else pass++;
    total++; if (cmd_ready !== 1'b0) $display("FAIL full_ready: got %0b expected 0", cmd_ready); else pass++;
    step();
    total++; if (cmd_ready !== 1'b0 || acc_cyc.size() !== 4) $display("FAIL full_hold: got ready=%0b acc=%0d expected 0/4", cmd_ready, acc_cyc.size()); else pass++;
    bids_ready = 1;
    repeat (25) step();
    total++; if (st_q.size() !== 5 || rsp_q.size() !== 5 || acc_cyc.size() !== 5)
      $display("FAIL full_counts: got %0d/%0d/%0d expected 5/5/5", st_q.size(), rsp_q.size(), acc_cyc.size());
    else begin
      pass++;
      for (int i = 0; i < 5; i++) begin
        total++; if (st_q[i] !== {4'(i + 1), 32'(i + 100)}) $display("FAIL full_issue%0d: got %0h expected %0h", i, st_q[i], {4'(i + 1), 32'(i + 100)}); else pass++;
        total++; if (rsp_q[i] !== {4'(i + 1), 3'd0, 2'b00}) $display("FAIL full_rsp%0d: got %0h expected %0h", i, rsp_q[i], {4'(i + 1), 3'd0, 2'b00}); else pass++;
      end
      total++; if (acc_cyc[4] !== st_cyc[0] + 2) $display("FAIL full_refill: got %0d expected %0d", acc_cyc[4], st_cyc[0] + 2); else pass++;
    end
  endtask

  task automatic test_illegal();
    clr(); bids_ready = 1; bids_err = 3'd5;
    push_q.push_back({4'hC, 32'hDEAD});
    push_q.push_back({4'd2, 32'h55});
    repeat (12) step();
    total++; if (st_q.size() !== 1 || rsp_q.size() !== 2) $display("FAIL ill_counts: got %0d/%0d expected 1/2", st_q.size(), rsp_q.size());
    else begin
      pass++;
      total++; if (rsp_q[0] !== {4'hC, 3'd0, 2'b10}) $display("FAIL ill_rsp: got %0h expected %0h", rsp_q[0], {4'hC, 3'd0, 2'b10}); else pass++;
      total++; if (rsp_cyc[0] !== acc_cyc[0] + 2) $display("FAIL ill_lat: got %0d expected %0d", rsp_cyc[0], acc_cyc[0] + 2); else pass++;
      total++; if (st_q[0] !== {4'd2, 32'h55}) $display("FAIL ill_next_issue: got %0h expected %0h", st_q[0], {4'd2, 32'h55}); else pass++;
      total++; if (rsp_q[1] !== {4'd2, 3'd0, 2'b00}) $display("FAIL ill_next_rsp: got %0h expected %0h", rsp_q[1], {4'd2, 3'd0, 2'b00}); else pass++;
    end
  endtask

  task automatic test_timeout_reset();
    clr(); bids_ready = 0; bids_err = 3'd5;
    push_q.push_back({4'd7, 32'h100});
    repeat (14) step();
    total++; if (st_q.size() !== 0 || rsp_q.size() !== 1) $display("FAIL to_counts: got %0d/%0d expected 0/1", st_q.size(), rsp_q.size());
    else begin
      pass++;
      total++; if (rsp_q[0] !== {4'd7, 3'd0, 2'b01}) $display("FAIL to_rsp: got %0h expected %0h", rsp_q[0], {4'd7, 3'd0, 2'b01}); else pass++;
      total++; if (rsp_cyc[0] !== acc_cyc[0] + 9) $display("FAIL to_lat: got %0d expected %0d", rsp_cyc[0], acc_cyc[0] + 9); else pass++;
    end
    clr();
    for (int i = 0; i < 4; i++) push_q.push_back({4'(i + 1), 32'(i)});
    for (int i = 0; i < 8 && acc_cyc.size() < 4; i++) step();
    total++; if (fifo_count !== 3'd4) $display("FAIL rst_fill: got %0d expected 4", fifo_count); else pass++;
    reset = 1;
    repeat (2) step();
    reset = 0;
    total++; if (fifo_count !== 3'd0 || cmd_ready !== 1'b1) $display("FAIL rst_state: got count=%0d ready=%0b expected 0/1", fifo_count, cmd_ready); else pass++;
    bids_ready = 1;
    repeat (12) step();
    total++; if (rsp_q.size() !== 0 || st_q.size() !== 0) $display("FAIL rst_quiet: got rsp=%0d start=%0d expected 0/0", rsp_q.size(), st_q.size()); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_illegal();
    test_timeout_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
